// File: rtl/audio_adc_rx.sv
// WM8750 ADC capture: deserialises DSP-mode-B 16-bit stereo frames framed by
// the adclrc pulse and queues {left,right} words in a show-ahead FIFO.
module audio_adc_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_BITS = 32
) (
    input  logic        clk12,
    input  logic        reset12,
    input  logic        audio_adclrc,
    input  logic        audio_adcdat,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [15:0] sample_left,
    output logic [15:0] sample_right,
    output logic        frame_err,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic [15:0] frame_cnt,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PUSH  = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] sr_start;

    logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           occ;
    logic [FRAME_BITS-1:0] last_pop;
    logic [FRAME_BITS-1:0] head;
    logic                  full;
    logic                  push_req;
    logic                  do_push;
    logic                  do_pop;

    assign fsm_state = state;

    // A frame-sync edge always loads the current data bit as the new MSB.
    assign sr_start = {{(FRAME_BITS-1){1'b0}}, audio_adcdat};

    always_ff @(posedge clk12 or posedge reset12) begin
        if (reset12) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (audio_adclrc) begin
                        sr      <= sr_start;
                        bit_cnt <= CW'(1);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (audio_adclrc) begin
                        frame_err <= 1'b1;
                        sr        <= sr_start;
                        bit_cnt   <= CW'(1);
                    end else begin
                        sr      <= {sr[FRAME_BITS-2:0], audio_adcdat};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                            state <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    if (audio_adclrc) begin
                        sr      <= sr_start;
                        bit_cnt <= CW'(1);
                        state   <= ST_SHIFT;
                    end else begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Output handshake: the head word transfers on every rising clk12 where
    // sample_valid and sample_ready are both 1; valid never depends on ready.
    assign occ          = wr_ptr - rd_ptr;
    assign sample_valid = (occ != '0);
    assign full         = (occ == (AW+1)'(FIFO_DEPTH));
    assign push_req     = (state == ST_PUSH);
    assign do_pop       = sample_valid & sample_ready;
    assign do_push      = push_req & (~full | do_pop);

    assign head         = sample_valid ? mem[rd_ptr[AW-1:0]] : last_pop;
    assign sample_left  = head[FRAME_BITS-1 -: 16];
    assign sample_right = head[15:0];

    always_ff @(posedge clk12) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= sr;
        end
    end

    always_ff @(posedge clk12 or posedge reset12) begin
        if (reset12) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_pop  <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr   <= rd_ptr + (AW+1)'(1);
                last_pop <= mem[rd_ptr[AW-1:0]];
            end
            if (do_push) begin
                wr_ptr    <= wr_ptr + (AW+1)'(1);
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (push_req && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: stepped stimulus with a queue-based reference model
// checked every cycle, plus a vector table and directed corner sequences.
module tb_audio_adc_rx;
  localparam int DEPTH = 4;

  logic        clk12 = 1'b0;
  logic        reset12;
  logic        audio_adclrc;
  logic        audio_adcdat;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        frame_err;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] frame_cnt;
  logic [1:0]  fsm_state;

  audio_adc_rx #(.FIFO_DEPTH(DEPTH), .FRAME_BITS(32)) dut (
    .clk12(clk12), .reset12(reset12), .audio_adclrc(audio_adclrc), .audio_adcdat(audio_adcdat),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_left(sample_left),
    .sample_right(sample_right), .frame_err(frame_err), .overflow(overflow),
    .overflow_clr(overflow_clr), .frame_cnt(frame_cnt), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk12 = ~clk12;

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;
  int dut_pops = 0;

  always @(posedge clk12) if (sample_valid && sample_ready && !reset12) dut_pops <= dut_pops + 1;

  // reference model: frames in the FIFO, bits of the frame being received
  logic [31:0] exp_q[$];
  logic [31:0] last_pop;
  bit          m_bits[$];
  bit          m_cap, m_pend, m_err, m_ovf;
  logic [31:0] m_pend_data;
  logic [15:0] m_cnt;

  typedef struct {
    logic [31:0] frame;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_bits.delete();
    last_pop = '0;
    m_cap = 0; m_pend = 0; m_err = 0; m_ovf = 0;
    m_pend_data = '0;
    m_cnt = '0;
  endtask

  // What the next rising edge does, from the frame/FIFO rules alone.
  task automatic model_edge();
    bit pop, full, ovf_set;
    logic [31:0] f;
    ovf_set = 0;
    m_err = 0;
    pop  = (exp_q.size() > 0) && sample_ready;
    full = (exp_q.size() == DEPTH);
    if (pop) last_pop = exp_q.pop_front();
    if (m_pend) begin
      if (!full || pop) begin
        exp_q.push_back(m_pend_data);
        m_cnt = m_cnt + 16'd1;
      end else begin
        ovf_set = 1;
      end
      m_pend = 0;
    end
    if (ovf_set) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
    if (audio_adclrc) begin
      if (m_cap) m_err = 1;
      m_bits.delete();
      m_bits.push_back(audio_adcdat);
      m_cap = 1;
    end else if (m_cap) begin
      m_bits.push_back(audio_adcdat);
      if (m_bits.size() == 32) begin
        for (int i = 0; i < 32; i++) f[31-i] = m_bits[i];
        m_pend_data = f;
        m_pend = 1;
        m_cap = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] h;
    if (frame_err) err_pulses++;
    h = (exp_q.size() > 0) ? exp_q[0] : last_pop;
    chk("valid", sample_valid, exp_q.size() > 0);
    chk("left", sample_left, h[31:16]);
    chk("right", sample_right, h[15:0]);
    chk("frame_err", frame_err, m_err);
    chk("overflow", overflow, m_ovf);
    chk("frame_cnt", frame_cnt, m_cnt);
  endtask

  // driver tasks
  task automatic step(input bit lrc, input bit dat, input bit rdy, input bit clr);
    @(negedge clk12);
    check_outputs();
    audio_adclrc = lrc;
    audio_adcdat = dat;
    sample_ready = rdy;
    overflow_clr = clr;
    model_edge();
  endtask

  function automatic bit rsel(input int rmode);
    if (rmode == 2) return 1'($urandom_range(0, 1));
    return (rmode != 0);
  endfunction

  task automatic drive_frame(input logic [31:0] d, input int gap, input int rmode);
    step(1'b1, d[31], rsel(rmode), 1'b0);
    for (int i = 30; i >= 0; i--) step(1'b0, d[i], rsel(rmode), 1'b0);
    for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom_range(0, 1)), rsel(rmode), 1'b0);
  endtask

  task automatic drive_partial(input int nbits, input int rmode);
    step(1'b1, 1'($urandom_range(0, 1)), rsel(rmode), 1'b0);
    for (int i = 1; i < nbits; i++) step(1'b0, 1'($urandom_range(0, 1)), rsel(rmode), 1'b0);
  endtask

  initial begin
    int base_err, base_pops;
    logic [15:0] base_cnt;
    logic [31:0] f;

    tbl[0] = '{32'hE000_0400, 16'hE000, 16'h0400, 16'd1};
    tbl[1] = '{32'h1234_5678, 16'h1234, 16'h5678, 16'd2};
    tbl[2] = '{32'h8000_7FFF, 16'h8000, 16'h7FFF, 16'd3};
    tbl[3] = '{32'hFFFF_0000, 16'hFFFF, 16'h0000, 16'd4};
    tbl[4] = '{32'h0001_FFFE, 16'h0001, 16'hFFFE, 16'd5};

    reset12 = 1'b1; audio_adclrc = 1'b0; audio_adcdat = 1'b0;
    sample_ready = 1'b0; overflow_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk12);
    #1;
    chk("rst_valid", sample_valid, 0);
    chk("rst_left", sample_left, 0);
    chk("rst_right", sample_right, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", frame_cnt, 0);
    @(negedge clk12);
    reset12 = 1'b0;

    // bits before the first adclrc are ignored
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);

    // table: one frame each, valid exactly one cycle after the push edge
    for (int v = 0; v < 5; v++) begin
      drive_frame(tbl[v].frame, 1, 1);
      @(posedge clk12); #1;
      chk("tbl_valid", sample_valid, 1);
      chk("tbl_left", sample_left, tbl[v].exp_left);
      chk("tbl_right", sample_right, tbl[v].exp_right);
      chk("tbl_cnt", frame_cnt, tbl[v].exp_cnt);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end

    // 48 frames at a 250-cycle period
    base_err = err_pulses; base_pops = dut_pops;
    for (int i = 0; i < 48; i++) begin
      f = (i % 2 == 0) ? 32'h2000_0400 : 32'hE000_FC00;
      drive_frame(f, 250 - 32, 1);
    end
    chk("t2_pops", dut_pops - base_pops, 48);
    chk("t2_err", err_pulses - base_err, 0);

    // overflow with ready low, then drain and clear
    base_cnt = m_cnt; base_pops = dut_pops;
    for (int i = 0; i <= DEPTH; i++) drive_frame(32'hA000_0000 + i, 2, 0);
    @(posedge clk12); #1;
    chk("t3_ovf", overflow, 1);
    chk("t3_cnt", frame_cnt, base_cnt + 16'd4);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_pops", dut_pops - base_pops, 4);
    chk("t3_ovf_clr", overflow, 0);
    chk("t3_empty", sample_valid, 0);

    // adclrc re-asserted where bit 10 would be captured
    base_err = err_pulses;
    drive_partial(21, 1);
    drive_frame(32'h1234_5678, 1, 0);
    @(posedge clk12); #1;
    chk("t4_err", err_pulses - base_err, 1);
    chk("t4_left", sample_left, 16'h1234);
    chk("t4_right", sample_right, 16'h5678);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // full FIFO with push and pop on the same edge
    for (int i = 0; i < DEPTH; i++) drive_frame(32'hC000_0000 + i, 1, 0);
    drive_frame(32'h5555_AAAA, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk12); #1;
    chk("t5_valid", sample_valid, 1);
    chk("t5_newest", {sample_left, sample_right}, 32'h5555_AAAA);
    chk("t5_ovf", overflow, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // async reset at bit 20 with two frames queued
    drive_frame(32'h0102_0304, 1, 0);
    drive_frame(32'h0506_0708, 1, 0);
    drive_partial(12, 0);
    #1 reset12 = 1'b1;
    audio_adclrc = 1'b0; audio_adcdat = 1'b0; sample_ready = 1'b0;
    #1;
    chk("t6_valid", sample_valid, 0);
    chk("t6_cnt", frame_cnt, 0);
    chk("t6_left", sample_left, 0);
    model_reset();
    @(negedge clk12);
    reset12 = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    drive_frame(32'h7FFF_8001, 1, 1);
    @(posedge clk12); #1;
    chk("t6_cnt_after", frame_cnt, 1);
    chk("t6_frame", {sample_left, sample_right}, 32'h7FFF_8001);

    // randomized frames, gaps, aborts and consumer back-pressure
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) drive_partial($urandom_range(1, 31), 2);
      drive_frame($urandom, $urandom_range(0, 4), 2);
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
